fifo_sync: RTL and testbench
============================

FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 Parameter WIDTH, default 8, is the data word width in bits.
REQ-002 Parameter DEPTH, default 256, is the number of storage words; any value >= 2, power of two not required.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_wr_dv  input  1  write request; i_wr_data is written when accepted.
REQ-006 i_wr_data  input  WIDTH  write data.
REQ-007 i_af_level  input  $clog2(DEPTH)+1  almost-full threshold in words.
REQ-008 o_af_flag  output  1  almost-full flag.
REQ-009 o_full  output  1  FIFO holds DEPTH words.
REQ-010 i_rd_en  input  1  read request.
REQ-011 i_ae_level  input  $clog2(DEPTH)+1  almost-empty threshold in words.
REQ-012 o_rd_dv  output  1  o_rd_data valid this cycle.
REQ-013 o_rd_data  output  WIDTH  read data.
REQ-014 o_ae_flag  output  1  almost-empty flag.
REQ-015 o_empty  output  1  FIFO holds 0 words.
REQ-016 o_count  output  $clog2(DEPTH)+1  words currently stored.
REQ-017 o_ovf  output  1  one-cycle pulse: write rejected because full.
REQ-018 o_udf  output  1  one-cycle pulse: read rejected because empty.

Function
REQ-019 Storage SHALL be an internal WIDTH x DEPTH array with synchronous write and a registered, one-cycle read; the array itself is not reset.
REQ-020 Write accept = i_wr_dv & (~o_full | read accept); an accepted write stores i_wr_data at wr_ptr and advances wr_ptr.
REQ-021 Read accept = i_rd_en & ~o_empty; an accepted read fetches word at rd_ptr and advances rd_ptr.
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0 by explicit compare, not by bit overflow.
REQ-023 Read latency: in the cycle after a read accept, o_rd_dv = 1 and o_rd_data = the fetched word; otherwise o_rd_dv = 0 and o_rd_data holds its last value.
REQ-024 o_count: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither; never exceeds DEPTH nor goes below 0.
REQ-025 Simultaneous write+read when empty: read rejected (o_udf = 1), write accepted, o_count -> 1.
REQ-026 Simultaneous write+read when full: both accepted, o_count stays DEPTH, o_ovf = 0.
REQ-027 Write with o_full = 1 and no read accept: write dropped, storage unchanged, o_ovf = 1 next cycle for one cycle.
REQ-028 Read with o_empty = 1: no pointer change, o_rd_dv = 0 next cycle, o_udf = 1 next cycle for one cycle.
REQ-029 o_full = (o_count == DEPTH); o_empty = (o_count == 0); both decoded from registered o_count, no extra latency.
REQ-030 o_af_flag = (o_count >= i_af_level); o_ae_flag = (o_count <= i_ae_level); combinational from registered o_count and current thresholds.
REQ-031 Data SHALL emerge in write order with no loss or duplication under any legal request pattern.

Reset
REQ-032 While i_rst_n = 0: wr_ptr, rd_ptr, o_count = 0; o_empty = 1; o_full = 0; o_rd_dv, o_ovf, o_udf = 0; o_rd_data = 0.
REQ-033 Reset asserted mid-operation SHALL discard all stored words and any read in flight (no o_rd_dv after release).
REQ-034 First accepted request SHALL be on the first rising edge with i_rst_n = 1.

Verification (WIDTH=8, DEPTH=4, i_af_level=3, i_ae_level=1)
REQ-035 Write 0x11,0x22,0x33,0x44 then read 4 -> o_rd_data 0x11,0x22,0x33,0x44 each one cycle after i_rd_en, o_rd_dv high 4 cycles, o_empty = 1 at end.
REQ-036 Fill to 4, write 0x55 -> o_full = 1, o_ovf pulses once, subsequent reads return 0x11..0x44 only.
REQ-037 Read while empty, then write+read same cycle while empty -> o_udf pulses each time, o_count = 1, o_rd_dv stays 0.
REQ-038 Full, write 0x66 + read same cycle -> o_count stays 4, o_ovf = 0, read returns oldest word, 0x66 emerges last.
REQ-039 Write 6, read 6 interleaved to cross pointer wrap -> order preserved; o_ae_flag = 1 at count <= 1; o_af_flag = 1 at count >= 3.
REQ-040 Hold 3 words, assert i_rst_n = 0 mid-cycle with read pending -> outputs at reset values immediately, no o_rd_dv after release, o_count = 0.

Source files
------------

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered read port, occupancy count,
// programmable almost-full/almost-empty flags and overflow/underflow pulses.
module fifo_sync #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 256,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_dv,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [CW-1:0]    i_af_level,
    output logic             o_af_flag,
    output logic             o_full,
    input  logic             i_rd_en,
    input  logic [CW-1:0]    i_ae_level,
    output logic             o_rd_dv,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_ae_flag,
    output logic             o_empty,
    output logic [CW-1:0]    o_count,
    output logic             o_ovf,
    output logic             o_udf
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_rd_dv;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_ovf;
    logic             r_udf;

    logic             w_rd_acc;
    logic             w_wr_acc;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

    // A read frees a slot this cycle, so a full FIFO can still take a write.
    assign w_rd_acc = i_rd_en & ~o_empty;
    assign w_wr_acc = i_wr_dv & (~o_full | w_rd_acc);

    assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_dv   <= 1'b0;
            r_rd_data <= '0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_acc) begin
                r_rd_ptr  <= w_rd_ptr_nxt;
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_rd_dv <= w_rd_acc;
            r_ovf   <= i_wr_dv & ~w_wr_acc;
            r_udf   <= i_rd_en & ~w_rd_acc;
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr_acc && w_rd_acc) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_count   = r_count;
    assign o_rd_dv   = r_rd_dv;
    assign o_rd_data = r_rd_data;
    assign o_ovf     = r_ovf;
    assign o_udf     = r_udf;
    assign o_af_flag = (r_count >= i_af_level);
    assign o_ae_flag = (r_count <= i_ae_level);

endmodule

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync at WIDTH=8, DEPTH=4,
// almost-full threshold 3 and almost-empty threshold 1.
module tb_fifo_sync;

    logic       clk;
    logic       rst_n;
    logic       wr_dv;
    logic [7:0] wr_data;
    logic       af_flag;
    logic       full;
    logic       rd_en;
    logic       rd_dv;
    logic [7:0] rd_data;
    logic       ae_flag;
    logic       empty;
    logic [2:0] count;
    logic       ovf;
    logic       udf;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_sync #(.WIDTH(8), .DEPTH(4)) u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wr_dv    (wr_dv),
        .i_wr_data  (wr_data),
        .i_af_level (3'd3),
        .o_af_flag  (af_flag),
        .o_full     (full),
        .i_rd_en    (rd_en),
        .i_ae_level (3'd1),
        .o_rd_dv    (rd_dv),
        .o_rd_data  (rd_data),
        .o_ae_flag  (ae_flag),
        .o_empty    (empty),
        .o_count    (count),
        .o_ovf      (ovf),
        .o_udf      (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic wr, input logic [7:0] d, input logic rd);
        wr_dv   = wr;
        wr_data = d;
        rd_en   = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        n_cmp++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || rd_dv !== 1'b0 ||
            rd_data !== 8'h00 || ovf !== 1'b0 || udf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: cnt=%0d emp=%b full=%b dv=%b data=%h ovf=%b udf=%b, want 0 1 0 0 00 0 0",
                     count, empty, full, rd_dv, rd_data, ovf, udf);
        end
        n_cmp++;
        if (ae_flag !== 1'b1 || af_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: ae=%b af=%b, want 1 0", ae_flag, af_flag);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [7:0] d [4];
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, d[i], 1'b0);
            n_cmp++;
            if (count !== 3'(i + 1) || af_flag !== (i + 1 >= 3) ||
                ae_flag !== (i + 1 <= 1) || full !== (i == 3) || empty !== 1'b0) begin
                n_bad++;
                $display("FAIL basic_wr%0d: cnt=%0d af=%b ae=%b full=%b emp=%b, want cnt=%0d",
                         i, count, af_flag, ae_flag, full, empty, i + 1);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            n_cmp++;
            if (rd_dv !== 1'b1 || rd_data !== d[i] || count !== 3'(3 - i)) begin
                n_bad++;
                $display("FAIL basic_rd%0d: dv=%b data=%h cnt=%0d, want 1 %h %0d",
                         i, rd_dv, rd_data, count, d[i], 3 - i);
            end
        end
        drive(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (rd_dv !== 1'b0 || rd_data !== 8'h44 || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_end: dv=%b data=%h emp=%b, want 0 44 1", rd_dv, rd_data, empty);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] d [4];
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) drive(1'b1, d[i], 1'b0);
        drive(1'b1, 8'h55, 1'b0);
        n_cmp++;
        if (ovf !== 1'b1 || full !== 1'b1 || count !== 3'd4) begin
            n_bad++;
            $display("FAIL ovf_pulse: ovf=%b full=%b cnt=%0d, want 1 1 4", ovf, full, count);
        end
        drive(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear: ovf=%b, want 0", ovf);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            n_cmp++;
            if (rd_dv !== 1'b1 || rd_data !== d[i]) begin
                n_bad++;
                $display("FAIL ovf_rd%0d: dv=%b data=%h, want 1 %h", i, rd_dv, rd_data, d[i]);
            end
        end
        drive(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (rd_dv !== 1'b0 || empty !== 1'b1 || udf !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_drained: dv=%b emp=%b udf=%b, want 0 1 1", rd_dv, empty, udf);
        end
    endtask

    task automatic test_underflow;
        drive(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (udf !== 1'b1 || rd_dv !== 1'b0 || count !== 3'd0) begin
            n_bad++;
            $display("FAIL udf_rd: udf=%b dv=%b cnt=%0d, want 1 0 0", udf, rd_dv, count);
        end
        drive(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (udf !== 1'b0) begin
            n_bad++;
            $display("FAIL udf_clear: udf=%b, want 0", udf);
        end
        drive(1'b1, 8'h77, 1'b1);
        n_cmp++;
        if (udf !== 1'b1 || count !== 3'd1 || rd_dv !== 1'b0 || empty !== 1'b0) begin
            n_bad++;
            $display("FAIL udf_wr_rd: udf=%b cnt=%0d dv=%b emp=%b, want 1 1 0 0", udf, count, rd_dv, empty);
        end
        drive(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (udf !== 1'b0 || rd_dv !== 1'b0) begin
            n_bad++;
            $display("FAIL udf_idle: udf=%b dv=%b, want 0 0", udf, rd_dv);
        end
        drive(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (rd_dv !== 1'b1 || rd_data !== 8'h77 || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL udf_readout: dv=%b data=%h emp=%b, want 1 77 1", rd_dv, rd_data, empty);
        end
    endtask

    task automatic test_full_rw;
        logic [7:0] d [4];
        logic [7:0] e [4];
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        e = '{8'h22, 8'h33, 8'h44, 8'h66};
        for (int i = 0; i < 4; i++) drive(1'b1, d[i], 1'b0);
        drive(1'b1, 8'h66, 1'b1);
        n_cmp++;
        if (count !== 3'd4 || ovf !== 1'b0 || full !== 1'b1 || rd_dv !== 1'b1 || rd_data !== 8'h11) begin
            n_bad++;
            $display("FAIL full_rw: cnt=%0d ovf=%b full=%b dv=%b data=%h, want 4 0 1 1 11",
                     count, ovf, full, rd_dv, rd_data);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            n_cmp++;
            if (rd_dv !== 1'b1 || rd_data !== e[i]) begin
                n_bad++;
                $display("FAIL full_rw_rd%0d: dv=%b data=%h, want 1 %h", i, rd_dv, rd_data, e[i]);
            end
        end
        drive(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (empty !== 1'b1) begin
            n_bad++;
            $display("FAIL full_rw_end: emp=%b, want 1", empty);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] a [6];
        a = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        for (int i = 0; i < 3; i++) drive(1'b1, a[i], 1'b0);
        n_cmp++;
        if (count !== 3'd3 || af_flag !== 1'b1 || ae_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_w3: cnt=%0d af=%b ae=%b, want 3 1 0", count, af_flag, ae_flag);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            n_cmp++;
            if (rd_dv !== 1'b1 || rd_data !== a[i] || count !== 3'(2 - i) ||
                af_flag !== 1'b0 || ae_flag !== (2 - i <= 1)) begin
                n_bad++;
                $display("FAIL wrap_rdA%0d: dv=%b data=%h cnt=%0d af=%b ae=%b, want data %h",
                         i, rd_dv, rd_data, count, af_flag, ae_flag, a[i]);
            end
        end
        for (int i = 3; i < 6; i++) drive(1'b1, a[i], 1'b0);
        n_cmp++;
        if (count !== 3'd4 || full !== 1'b1 || af_flag !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_w6: cnt=%0d full=%b af=%b, want 4 1 1", count, full, af_flag);
        end
        for (int j = 0; j < 4; j++) begin
            drive(1'b0, 8'h00, 1'b1);
            n_cmp++;
            if (rd_dv !== 1'b1 || rd_data !== a[j + 2] || count !== 3'(3 - j) ||
                af_flag !== (3 - j >= 3) || ae_flag !== (3 - j <= 1)) begin
                n_bad++;
                $display("FAIL wrap_rdB%0d: dv=%b data=%h cnt=%0d af=%b ae=%b, want data %h",
                         j, rd_dv, rd_data, count, af_flag, ae_flag, a[j + 2]);
            end
        end
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 8'hB1, 1'b0);
        drive(1'b1, 8'hB2, 1'b0);
        drive(1'b1, 8'hB3, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (rd_dv !== 1'b1 || rd_data !== 8'hB1 || count !== 3'd2) begin
            n_bad++;
            $display("FAIL rstmid_pre: dv=%b data=%h cnt=%0d, want 1 b1 2", rd_dv, rd_data, count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || rd_dv !== 1'b0 ||
            rd_data !== 8'h00 || ovf !== 1'b0 || udf !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_async: cnt=%0d emp=%b full=%b dv=%b data=%h ovf=%b udf=%b, want 0 1 0 0 00 0 0",
                     count, empty, full, rd_dv, rd_data, ovf, udf);
        end
        drive(1'b0, 8'h00, 1'b0);
        #2;
        rst_n = 1'b1;
        drive(1'b1, 8'h99, 1'b0);
        n_cmp++;
        if (rd_dv !== 1'b0 || count !== 3'd1) begin
            n_bad++;
            $display("FAIL rstmid_first: dv=%b cnt=%0d, want 0 1", rd_dv, count);
        end
        drive(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (rd_dv !== 1'b1 || rd_data !== 8'h99 || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_read: dv=%b data=%h emp=%b, want 1 99 1", rd_dv, rd_data, empty);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_dv   = 1'b0;
        wr_data = 8'h00;
        rd_en   = 1'b0;
        test_reset;
        test_basic;
        test_overflow;
        test_underflow;
        test_full_rw;
        test_wrap;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
